// File: rtl/fsmd_capture_buffer_if.sv
// Drain-side handshake between the capture buffer and its consumer.
// The buffer drives valid/data as master; the consumer drives ready as slave.
interface fsmd_capture_buffer_if #(
  parameter int WIDTH = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fsmd_capture_buffer.sv
// Capture FIFO behind the 1010 detector: queues datapath words on match and drains them over valid/ready.
// Optional statistics (drop_cnt, total_cnt) are built when CAPTURE_STATS_EN is defined.
module fsmd_capture_buffer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int CAP_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     match_in,
  input  logic [WIDTH-1:0]         word_in,
  input  logic                     clr_ovf,
  fsmd_capture_buffer_if.master    bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
`ifdef CAPTURE_STATS_EN
  ,
  output logic [7:0]               drop_cnt,
  output logic [15:0]              total_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             cap_wr;
  logic             full_w;
  logic             rd_en;
  logic             wr_ok;
  logic             drop;

  // Capture strobe: either the registered match (word arrives a cycle later) or the raw match
  generate
    if (CAP_LATENCY == 1) begin : g_lat1
      logic cap_q;
      always_ff @(posedge clk) begin
        if (reset) cap_q <= 1'b0;
        else       cap_q <= match_in;
      end
      assign cap_wr = cap_q;
    end else begin : g_lat0
      assign cap_wr = match_in;
    end
  endgenerate

  assign full_w = (count_q == CNT_W'(DEPTH));
  assign rd_en  = (count_q != '0) && bus.out_ready;
  // A full FIFO still accepts a capture when the head leaves on the same edge
  assign wr_ok  = cap_wr && (!full_w || rd_en);
  assign drop   = cap_wr && full_w && !rd_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_ok, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is data only; pointers and count define which entries are meaningful
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem_q[wr_ptr_q] <= word_in;
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count         = count_q;
  assign full          = full_w;
  assign overflow      = ovf_q;

`ifdef CAPTURE_STATS_EN
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [15:0] total_cnt_q, total_cnt_d;

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    total_cnt_d = total_cnt_q;
    if (clr_ovf)                          drop_cnt_d = drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    if (wr_ok) total_cnt_d = total_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q  <= '0;
      total_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      total_cnt_q <= total_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign total_cnt = total_cnt_q;
`endif

endmodule

// File: tb/tb_fsmd_capture_buffer.sv
// Directed bench for fsmd_capture_buffer (WIDTH=16, DEPTH=4, CAP_LATENCY=1).
// Define CAPTURE_STATS_EN on both design and bench to also check the statistics counters.
module tb_fsmd_capture_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        match_in;
  logic [15:0] word_in;
  logic        clr_ovf;
  logic [2:0]  count;
  logic        full;
  logic        overflow;
`ifdef CAPTURE_STATS_EN
  logic [7:0]  drop_cnt;
  logic [15:0] total_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fsmd_capture_buffer_if #(.WIDTH(16)) bus ();

  fsmd_capture_buffer #(.WIDTH(16), .DEPTH(4), .CAP_LATENCY(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .match_in (match_in),
    .word_in  (word_in),
    .clr_ovf  (clr_ovf),
    .bus      (bus.master),
    .count    (count),
    .full     (full),
    .overflow (overflow)
`ifdef CAPTURE_STATS_EN
    ,
    .drop_cnt (drop_cnt),
    .total_cnt(total_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Match pulse, then the word one cycle later; the word is written on the second edge
  task automatic capture(input logic [15:0] w);
    match_in = 1'b1;
    step();
    match_in = 1'b0;
    word_in  = w;
    step();
  endtask

  initial begin
    reset = 1'b1; match_in = 1'b1; bus.out_ready = 1'b1; word_in = 16'h0; clr_ovf = 1'b0;

    // Reset held three cycles with match and ready asserted
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
    end
    reset = 1'b0; match_in = 1'b0;
    step();
    chk("post_rst_count0", 32'(count), 32'd0);
    step();
    chk("post_rst_count1", 32'(count), 32'd0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

    // Single capture latency with consumer stalled
    bus.out_ready = 1'b0;
    match_in = 1'b1;
    step();
    chk("lat_count_n1", 32'(count), 32'd0);
    match_in = 1'b0; word_in = 16'hA5A5;
    step();
    chk("lat_count", 32'(count), 32'd1);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data", 32'(bus.out_data), 32'hA5A5);
    step();
    chk("stall_data", 32'(bus.out_data), 32'hA5A5);
    bus.out_ready = 1'b1;
    step();
    chk("drain1_count", 32'(count), 32'd0);
    step();
    chk("empty_ready_count", 32'(count), 32'd0);
    chk("empty_ready_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Fill to full, then one dropped capture
    for (int i = 1; i <= 4; i++) capture(16'(i));
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf", 32'(overflow), 32'd0);
    capture(16'h0005);
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_full", 32'(full), 32'd1);
    chk("drop_ovf", 32'(overflow), 32'd1);
`ifdef CAPTURE_STATS_EN
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
`endif
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(bus.out_data), 32'(i));
      step();
    end
    chk("drain_empty", 32'(count), 32'd0);
    bus.out_ready = 1'b0;
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Capture into a full FIFO while the head is read on the same edge
    for (int i = 0; i < 4; i++) capture(16'h0011 + 16'(i));
    match_in = 1'b1;
    step();
    match_in = 1'b0; word_in = 16'hBEEF; bus.out_ready = 1'b1;
    step();
    chk("fullrw_count", 32'(count), 32'd4);
    chk("fullrw_ovf", 32'(overflow), 32'd0);
    chk("fullrw_head", 32'(bus.out_data), 32'h0012);
    step();
    chk("fullrw_d2", 32'(bus.out_data), 32'h0013);
    step();
    chk("fullrw_d3", 32'(bus.out_data), 32'h0014);
    step();
    chk("fullrw_beef", 32'(bus.out_data), 32'hBEEF);
    step();
    chk("fullrw_empty", 32'(count), 32'd0);

    // Eight write/read pairs across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      match_in = 1'b1;
      step();
      chk("pace_count_rd", 32'(count), 32'd0);
      match_in = 1'b0; word_in = 16'h1000 + 16'(i);
      step();
      chk("pace_count_wr", 32'(count), 32'd1);
      chk("pace_data", 32'(bus.out_data), 32'h1000 + 32'(i));
    end
    step();
    chk("pace_final", 32'(count), 32'd0);
    bus.out_ready = 1'b0;

    // Overflow clear coinciding with a drop, then clear alone
    for (int i = 0; i < 4; i++) capture(16'h2000 + 16'(i));
    capture(16'h2004);
    chk("ovf2_set", 32'(overflow), 32'd1);
    match_in = 1'b1;
    step();
    match_in = 1'b0; word_in = 16'h2005; clr_ovf = 1'b1;
    step();
    chk("ovf2_coincide", 32'(overflow), 32'd1);
`ifdef CAPTURE_STATS_EN
    chk("drop_cnt_coincide", 32'(drop_cnt), 32'd1);
`endif
    step();
    clr_ovf = 1'b0;
    chk("ovf2_cleared", 32'(overflow), 32'd0);
    chk("ovf2_count", 32'(count), 32'd4);
    chk("ovf2_head", 32'(bus.out_data), 32'h2000);
`ifdef CAPTURE_STATS_EN
    chk("drop_cnt_cleared", 32'(drop_cnt), 32'd0);
    chk("total_cnt", 32'(total_cnt), 32'd22);
`endif

    // Reset while entries are queued discards them
    bus.out_ready = 1'b1;
    step();
    chk("middrain_count", 32'(count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("middrain_rst_count", 32'(count), 32'd0);
    chk("middrain_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("middrain_rst_data", 32'(bus.out_data), 32'd0);
    step();
    chk("middrain_after", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsmd_capture_buffer.md
Name: fsmd_capture_buffer

Overview:
- Downstream stage of the 1010-detector/16-bit datapath FSMD.
- Consumes the detector match pulse and the datapath's registered 16-bit word, and queues each captured word in a small FIFO.
- Drains the FIFO to a consumer over a valid/ready handshake.
- Reports occupancy and a sticky overflow flag.

Parameters:
- WIDTH, 16, captured word width (matches the datapath output).
- DEPTH, 4, FIFO entries; must be a power of two, 2..16.
- CAP_LATENCY, 1, cycles between match pulse and valid word on word_in; legal values 0 or 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- match_in  input  1  detector match pulse (one cycle per detected 1010).
- word_in  input  WIDTH  datapath output word.
- clr_ovf  input  1  one-cycle pulse that clears the overflow flag.
- out_ready  input  1  consumer ready.
- out_valid  output  1  head entry available.
- out_data  output  WIDTH  head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a capture was dropped.

Behaviour:
- Reset (synchronous, at the clk edge with reset=1):
  - out_valid=0, out_data=0, count=0, full=0, overflow=0.
  - Read/write pointers cleared; the capture delay register cleared.
  - Any in-flight capture is discarded. A reset mid-drain loses all queued entries.
- Capture strobe cap_wr:
  - CAP_LATENCY=1: cap_wr = match_in registered one cycle.
  - CAP_LATENCY=0: cap_wr = match_in directly.
  - When cap_wr=1, word_in is sampled in that same cycle.
- Write: on a clk edge with cap_wr=1 and (not full, or a read occurring the same edge), word_in is written at the write pointer, and the write pointer increments modulo DEPTH.
- Read:
  - A read occurs on an edge where out_valid=1 and out_ready=1.
  - The read pointer increments modulo DEPTH.
  - out_data shows the new head after the edge.
- Output timing:
  - out_valid = (count != 0); out_data = mem[read pointer]. Both are driven from registered state.
  - No combinational bypass: a word written into an empty FIFO appears on out_valid/out_data the cycle after the write edge.
- Occupancy:
  - count increments on write only, decrements on read only, and is unchanged on a simultaneous write and read.
  - full = (count == DEPTH).
- Full boundary:
  - With cap_wr=1, full=1 and no read that edge: the word is dropped and overflow is set to 1.
  - With full=1, cap_wr=1 and a read that edge: the write is accepted, count stays DEPTH, and no overflow occurs.
- Empty boundary: out_ready is ignored while out_valid=0; count never underflows.
- Pointer wrap: pointers wrap from DEPTH-1 to 0; FIFO order is preserved across the wrap.
- overflow flag:
  - Set on any dropped capture; holds until clr_ovf=1 or reset.
  - If clr_ovf and a drop coincide on the same edge, set wins (overflow=1).
- Handshake rule: while out_valid=1 and out_ready=0, out_data must remain stable.

Optional Feature:
- Macro: CAPTURE_STATS_EN.
- Defined:
  - Adds output drop_cnt [7:0], which increments on every dropped capture and saturates at 255.
  - Cleared by reset and by clr_ovf. If clr_ovf and a drop coincide, drop_cnt = 1.
  - Also adds output total_cnt [15:0], which increments on every accepted write, wraps at 65535->0, and is cleared only by reset.
- Not defined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset 3 cycles with match_in=1 and out_ready=1 -> out_valid=0, count=0, overflow=0 throughout; no write after reset releases until the next match.
- CAP_LATENCY=1, out_ready=0: match_in pulse at cycle N, word_in=16'hA5A5 at N+1 -> count=1 and out_valid=1 at N+2, out_data=16'hA5A5.
- Four captures 16'h0001..16'h0004 with out_ready=0, then a fifth 16'h0005 -> full=1, count=4, overflow=1; draining yields 0001,0002,0003,0004 in order.
- Full FIFO, out_ready=1 on the same edge as a capture of 16'hBEEF -> count stays 4, overflow stays 0; BEEF is read out after the three older entries plus the head.
- Eight write/read pairs with 16'h1000+i, spanning pointer wrap -> outputs in exact order; count never exceeds 1 when read keeps pace.
- Overflow set, then clr_ovf pulse on the same edge as a further drop -> overflow=1; clr_ovf alone on the next cycle -> overflow=0. With CAPTURE_STATS_EN, drop_cnt=1 after the coincident edge.
